// File: rtl/id_ex_if.sv
// id_ex_if: signal bundle for the ID/EX pipeline register.
//   master : decode side + hazard controls + EX/MEM and MEM/WB bypass sources
//            (drives id_*, stall/hold/flush, exm_*, mwb_*; receives ex/alu outputs)
//   slave  : the id_ex_stage itself (mirror image of master)
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
);
  // decode side
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]        id_shamt;
  logic [CTRL_W-1:0] id_alu_ctrl;
  logic              id_alusrc, id_shvar, id_reg_write, id_mem_read, id_mem_write;
  // pipeline control
  logic              stall, hold, flush;
  // bypass sources
  logic              exm_reg_write, mwb_reg_write;
  logic [REG_AW-1:0] exm_rd, mwb_rd;
  logic [DATA_W-1:0] exm_result, mwb_result;
  // execute side
  logic              ex_valid;
  logic [DATA_W-1:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]        alu_shamt;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic              load_use_haz;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_alu_ctrl, id_alusrc, id_shvar, id_reg_write,
           id_mem_read, id_mem_write, stall, hold, flush,
           exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
    input  ex_valid, alu_in1, alu_in2, alu_shamt, alu_ctrl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, load_use_haz, bubble_count
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_alu_ctrl, id_alusrc, id_shvar, id_reg_write,
           id_mem_read, id_mem_write, stall, hold, flush,
           exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
    output ex_valid, alu_in1, alu_in2, alu_shamt, alu_ctrl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, load_use_haz, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with operand forwarding.
//   clk, reset : clock and synchronous active-high reset
//   bus        : id_ex_if.slave -- decode fields in, stall/hold/flush in,
//                EX/MEM + MEM/WB bypass in; ALU operands, registered control,
//                load-use hazard flag and saturating bubble counter out.
// Edge priority: reset > flush > hold > stall > load. Operands are resolved
// combinationally from the registered slot, so id->alu latency is one clock.
module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CTRL_W      = 4,
  parameter int NUM_ALU_OPS = 13,
  parameter int CNT_W       = 16
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [CTRL_W-1:0] ctrl;
    logic              alusrc;
    logic              shvar;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
  } slot_t;

  slot_t             r_slot;
  logic [CNT_W-1:0]  r_bcnt;

  logic              w_illegal;
  logic              w_bubble;
  logic [CNT_W-1:0]  w_bcnt_inc;
  logic [DATA_W-1:0] w_fwd_rs, w_fwd_rt;

  // Extra top bit keeps the compare exact even if NUM_ALU_OPS == 2**CTRL_W.
  assign w_illegal  = {1'b0, bus.id_alu_ctrl} >= (CTRL_W+1)'(NUM_ALU_OPS);
  assign w_bubble   = bus.stall | ~bus.id_valid | w_illegal;
  assign w_bcnt_inc = (r_bcnt == '1) ? r_bcnt : r_bcnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
      r_bcnt <= '0;
    end else if (bus.flush) begin
      r_slot <= '0;
      r_bcnt <= w_bcnt_inc;
    end else if (!bus.hold) begin
      if (w_bubble) begin
        r_slot         <= '0;
        // Only a real, unstalled instruction with a bad opcode is flagged.
        r_slot.illegal <= ~bus.stall & bus.id_valid & w_illegal;
        r_bcnt         <= w_bcnt_inc;
      end else begin
        r_slot.valid     <= 1'b1;
        r_slot.rs_addr   <= bus.id_rs_addr;
        r_slot.rt_addr   <= bus.id_rt_addr;
        r_slot.rd        <= bus.id_rd_addr;
        r_slot.rs_data   <= bus.id_rs_data;
        r_slot.rt_data   <= bus.id_rt_data;
        r_slot.imm       <= bus.id_imm;
        r_slot.shamt     <= bus.id_shamt;
        r_slot.ctrl      <= bus.id_alu_ctrl;
        r_slot.alusrc    <= bus.id_alusrc;
        r_slot.shvar     <= bus.id_shvar;
        r_slot.reg_write <= bus.id_reg_write;
        r_slot.mem_read  <= bus.id_mem_read;
        r_slot.mem_write <= bus.id_mem_write;
        r_slot.illegal   <= 1'b0;
      end
    end
  end

  // Youngest producer wins; r0 is hard-wired zero so it never bypasses.
  always_comb begin
    w_fwd_rs = r_slot.rs_data;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == r_slot.rs_addr)
      w_fwd_rs = bus.exm_result;
    else if (bus.mwb_reg_write && bus.mwb_rd != '0 && bus.mwb_rd == r_slot.rs_addr)
      w_fwd_rs = bus.mwb_result;
  end

  always_comb begin
    w_fwd_rt = r_slot.rt_data;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == r_slot.rt_addr)
      w_fwd_rt = bus.exm_result;
    else if (bus.mwb_reg_write && bus.mwb_rd != '0 && bus.mwb_rd == r_slot.rt_addr)
      w_fwd_rt = bus.mwb_result;
  end

  assign bus.ex_valid      = r_slot.valid;
  assign bus.alu_in1       = w_fwd_rs;
  assign bus.alu_in2       = r_slot.alusrc ? r_slot.imm : w_fwd_rt;
  assign bus.alu_shamt     = r_slot.shvar ? w_fwd_rs[4:0] : r_slot.shamt;
  assign bus.alu_ctrl      = r_slot.ctrl;
  assign bus.ex_store_data = w_fwd_rt;
  assign bus.ex_rd         = r_slot.rd;
  assign bus.ex_reg_write  = r_slot.reg_write;
  assign bus.ex_mem_read   = r_slot.mem_read;
  assign bus.ex_mem_write  = r_slot.mem_write;
  assign bus.ex_illegal    = r_slot.illegal;
  assign bus.bubble_count  = r_bcnt;

  // A load in EX cannot bypass its data to the instruction now in ID.
  // rt only matters when it is actually read: as an ALU operand or as store data.
  assign bus.load_use_haz = r_slot.valid & r_slot.mem_read & (r_slot.rd != '0) & bus.id_valid &
                            ((bus.id_rs_addr == r_slot.rd) |
                             ((bus.id_rt_addr == r_slot.rd) & ~bus.id_alusrc) |
                             (bus.id_mem_write & (bus.id_rt_addr == r_slot.rd)));

endmodule
